// File: rtl/stall_sequencer_pkg.sv
// Shared definitions for the multi-cycle stall sequencer.
// Contents:
//   - opcode and control-field enums
//   - the control bundle struct and its flattened form
//   - the idle (NOP) bundle
//   - helpers for the sequence length and the segment-select width
package stall_sequencer_pkg;

  typedef enum logic [1:0] {POP = 2'd0, CBF = 2'd1, CBB = 2'd2} op_code;

  typedef enum logic {SS_IDLE = 1'b0, SS_RUN = 1'b1} stall_state_e;

  typedef enum logic {DISABLE = 1'b0, ENABLE = 1'b1} control_e;
  typedef enum logic [1:0] {ALU_INC, ALU_DEC, ALU_PASS, ALU_ADD} alu_op_e;
  typedef enum logic {ALU_FROM_CACHE, ALU_FROM_STACK} alu_src_e;
  typedef enum logic {ADDR_FROM_HEAD, ADDR_FROM_ALU} mem_addr_e;
  typedef enum logic {MEM_FROM_ACC, MEM_FROM_PC} mem_src_e;
  typedef enum logic [1:0] {MEM_NONE, MEM_READ, MEM_WRITE} mem_op_e;
  typedef enum logic {PC_INCREMENTED, PC_LOADED} pc_src_e;
  typedef enum logic {ACC_FROM_ALU, ACC_FROM_MEM} acc_src_e;
  typedef enum logic {CORE_S, STALL_S} state_e;

  typedef struct packed {
    control_e  cache_write;
    control_e  head_write;
    control_e  stack_write;
    control_e  acc_write;
    control_e  pc_write;
    control_e  loader_select;
    alu_op_e   alu_op;
    alu_src_e  alu_src;
    mem_addr_e mem_addr;
    mem_src_e  mem_src;
    mem_op_e   mem_op;
    pc_src_e   pc_src;
    acc_src_e  acc_src;
    state_e    state;
  } control_bundle_s;

  localparam int CONTROL_W = $bits(control_bundle_s);
  typedef logic [CONTROL_W-1:0] control_bundle_f;

  // Idle bundle: every enable off, ownership handed back to the core.
  localparam control_bundle_s STALL_NOP_BUNDLE = '{
    cache_write: DISABLE, head_write: DISABLE, stack_write: DISABLE,
    acc_write: DISABLE, pc_write: DISABLE, loader_select: DISABLE,
    alu_op: ALU_INC, alu_src: ALU_FROM_CACHE, mem_addr: ADDR_FROM_HEAD,
    mem_src: MEM_FROM_ACC, mem_op: MEM_NONE, pc_src: PC_INCREMENTED,
    acc_src: ACC_FROM_ALU, state: CORE_S};

  // Number of memory phases an instruction needs. CBF/CBB move the extra
  // PC words; with a single-word PC that is zero phases.
  function automatic int unsigned stall_len(op_code op, int unsigned pc_segs);
    if (op == CBF || op == CBB) return pc_segs - 1;
    return 1;
  endfunction

  function automatic int unsigned seg_width(int unsigned pc_segs);
    return (pc_segs > 1) ? $clog2(pc_segs) : 1;
  endfunction

endpackage

// File: rtl/stall_sequencer_if.sv
// Handshake bundle between the core controller and the stall sequencer.
// The master modport is the core/memory side (start, instruction, mem_ack).
// The slave modport is the sequencer (busy, done, seg_sel, controls).
interface stall_sequencer_if import stall_sequencer_pkg::*; #(
  parameter int PC_SEGS = 2
) ();
  localparam int SEG_W = seg_width(PC_SEGS);

  logic             start;
  op_code           instruction;
  logic             mem_ack;
  logic             busy;
  logic             done;
  logic [SEG_W-1:0] seg_sel;
  control_bundle_f  controls;

  modport master (output start, instruction, mem_ack,
                  input  busy, done, seg_sel, controls);
  modport slave  (input  start, instruction, mem_ack,
                  output busy, done, seg_sel, controls);
endinterface

// File: rtl/stall_sequencer_bundle_rom.sv
// stall_bundle_rom: pure combinational decode of the control bundle for one
// running phase.
// Ports:
//   op      latched opcode
//   last    current phase is the final one
//   mem_ack memory accepted this phase
//   bundle  control bundle for this phase
module stall_bundle_rom import stall_sequencer_pkg::*; (
  input  op_code          op,
  input  logic            last,
  input  logic            mem_ack,
  output control_bundle_s bundle
);
  always_comb begin
    bundle         = STALL_NOP_BUNDLE;
    bundle.acc_src = ACC_FROM_ALU;
    bundle.state   = STALL_S;
    case (op)
      CBF: begin
        bundle.cache_write   = ENABLE;
        bundle.alu_op        = ALU_INC;
        bundle.alu_src       = ALU_FROM_CACHE;
        bundle.loader_select = ENABLE;
        bundle.mem_addr      = ADDR_FROM_ALU;
        bundle.mem_src       = MEM_FROM_PC;
        bundle.mem_op        = MEM_WRITE;
        bundle.pc_src        = PC_INCREMENTED;
      end
      CBB: begin
        // The final word goes straight to the PC, not the cache.
        bundle.cache_write   = last ? DISABLE : ENABLE;
        bundle.alu_op        = ALU_DEC;
        bundle.alu_src       = ALU_FROM_CACHE;
        bundle.loader_select = ENABLE;
        bundle.mem_addr      = ADDR_FROM_ALU;
        bundle.mem_src       = MEM_FROM_ACC;
        bundle.mem_op        = MEM_READ;
        bundle.pc_src        = PC_LOADED;
      end
      default: begin
        bundle.cache_write   = DISABLE;
        bundle.alu_op        = ALU_DEC;
        bundle.alu_src       = ALU_FROM_STACK;
        bundle.loader_select = DISABLE;
        bundle.mem_addr      = ADDR_FROM_HEAD;
        bundle.mem_src       = MEM_FROM_ACC;
        bundle.mem_op        = MEM_WRITE;
        bundle.pc_src        = PC_INCREMENTED;
      end
    endcase
    // The PC update and the hand-back to the core happen only in the cycle
    // in which the final phase is accepted.
    if (last && mem_ack) begin
      bundle.pc_write = ENABLE;
      bundle.state    = CORE_S;
    end
  end
endmodule

// File: rtl/stall_sequencer.sv
// stall_sequencer: multi-cycle stall controller for instructions that need
// several memory operations. It owns the control bundle while busy.
// Ports:
//   clock  rising-edge clock
//   reset  synchronous, active-high
//   bus    slave side of stall_sequencer_if
//          (start/instruction/mem_ack in; busy/done/seg_sel/controls out)
// States:
//   SS_IDLE | NOP bundle out, waiting for start
//   SS_RUN  | stepping phases, advancing on mem_ack
module stall_sequencer import stall_sequencer_pkg::*; #(
  parameter int PC_SEGS = 2
) (
  input logic             clock,
  input logic             reset,
  stall_sequencer_if.slave bus
);
  localparam int SEG_W = seg_width(PC_SEGS);

  stall_state_e     state_q, state_d;
  logic [SEG_W-1:0] ph_q, ph_d;
  logic [SEG_W-1:0] last_idx_q, last_idx_d;
  op_code           op_q, op_d;
  logic             done_q, done_d;
  logic             last;
  int unsigned      start_len;
  control_bundle_s  run_bundle;

  assign start_len = stall_len(bus.instruction, PC_SEGS);
  assign last      = (ph_q == last_idx_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= SS_IDLE;
      ph_q       <= '0;
      last_idx_q <= '0;
      op_q       <= POP;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      last_idx_q <= last_idx_d;
      op_q       <= op_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    last_idx_d = last_idx_q;
    op_d       = op_q;
    done_d     = 1'b0;
    case (state_q)
      SS_IDLE: begin
        if (bus.start) begin
          if (start_len == 0) begin
            // Nothing to move: acknowledge without taking the bundle.
            done_d = 1'b1;
          end else begin
            op_d       = bus.instruction;
            last_idx_d = SEG_W'(start_len - 1);
            ph_d       = '0;
            state_d    = SS_RUN;
          end
        end
      end
      SS_RUN: begin
        if (bus.mem_ack) begin
          if (last) begin
            done_d  = 1'b1;
            state_d = SS_IDLE;
          end else begin
            ph_d = ph_q + SEG_W'(1);
          end
        end
      end
      default: state_d = SS_IDLE;
    endcase
  end

  stall_bundle_rom u_rom (
    .op      (op_q),
    .last    (last),
    .mem_ack (bus.mem_ack),
    .bundle  (run_bundle)
  );

  assign bus.busy     = (state_q == SS_RUN);
  assign bus.done     = done_q;
  // Segment 0 is moved by the core itself, so the loader starts at 1.
  assign bus.seg_sel  = (state_q == SS_RUN && (op_q == CBF || op_q == CBB))
                        ? ph_q + SEG_W'(1) : '0;
  assign bus.controls = (state_q == SS_RUN) ? control_bundle_f'(run_bundle)
                                            : control_bundle_f'(STALL_NOP_BUNDLE);
endmodule

// File: tb/tb_stall_sequencer.sv
// Directed self-checking bench for stall_sequencer at PC_SEGS = 1, 2, 3, 4.
module tb_stall_sequencer;
  import stall_sequencer_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  stall_sequencer_if #(.PC_SEGS(1)) bus1 ();
  stall_sequencer_if #(.PC_SEGS(2)) bus2 ();
  stall_sequencer_if #(.PC_SEGS(3)) bus3 ();
  stall_sequencer_if #(.PC_SEGS(4)) bus4 ();

  stall_sequencer #(.PC_SEGS(1)) u1 (.clock(clock), .reset(reset), .bus(bus1));
  stall_sequencer #(.PC_SEGS(2)) u2 (.clock(clock), .reset(reset), .bus(bus2));
  stall_sequencer #(.PC_SEGS(3)) u3 (.clock(clock), .reset(reset), .bus(bus3));
  stall_sequencer #(.PC_SEGS(4)) u4 (.clock(clock), .reset(reset), .bus(bus4));

  function automatic control_bundle_f mk(
    control_e cw, alu_op_e alu, alu_src_e asrc, control_e ls, mem_addr_e maddr,
    mem_src_e msrc, mem_op_e mop, pc_src_e psrc, control_e pcw, state_e st);
    control_bundle_s b;
    b.cache_write = cw;       b.head_write = DISABLE; b.stack_write = DISABLE;
    b.acc_write = DISABLE;    b.pc_write = pcw;       b.loader_select = ls;
    b.alu_op = alu;           b.alu_src = asrc;       b.mem_addr = maddr;
    b.mem_src = msrc;         b.mem_op = mop;         b.pc_src = psrc;
    b.acc_src = ACC_FROM_ALU; b.state = st;
    return control_bundle_f'(b);
  endfunction

  control_bundle_f NOP, POP_LAST, CBF_MID, CBF_LAST, CBB_MID, CBB_LAST, CBB_LAST_WAIT;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    total++; if (bus2.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", bus2.busy); end
    total++; if (bus2.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", bus2.done); end
    total++; if (bus4.seg_sel !== 2'd0) begin bad++; $display("FAIL reset_seg got=%0d want=0", bus4.seg_sel); end
    total++; if (bus2.controls !== NOP) begin bad++; $display("FAIL reset_ctl got=%h want=%h", bus2.controls, NOP); end
  endtask

  task automatic test_pop();
    tick();
    bus2.start = 1'b1; bus2.instruction = POP; bus2.mem_ack = 1'b1;
    #1;
    total++; if (bus2.busy !== 1'b0) begin bad++; $display("FAIL pop_idle_busy got=%0b want=0", bus2.busy); end
    tick();
    bus2.start = 1'b0;
    #1;
    total++; if (bus2.busy !== 1'b1) begin bad++; $display("FAIL pop_busy got=%0b want=1", bus2.busy); end
    total++; if (bus2.seg_sel !== 1'b0) begin bad++; $display("FAIL pop_seg got=%0d want=0", bus2.seg_sel); end
    total++; if (bus2.controls !== POP_LAST) begin bad++; $display("FAIL pop_ctl got=%h want=%h", bus2.controls, POP_LAST); end
    total++; if (bus2.done !== 1'b0) begin bad++; $display("FAIL pop_early_done got=%0b want=0", bus2.done); end
    tick();
    #1;
    total++; if (bus2.done !== 1'b1) begin bad++; $display("FAIL pop_done got=%0b want=1", bus2.done); end
    total++; if (bus2.busy !== 1'b0) begin bad++; $display("FAIL pop_end_busy got=%0b want=0", bus2.busy); end
    total++; if (bus2.controls !== NOP) begin bad++; $display("FAIL pop_end_ctl got=%h want=%h", bus2.controls, NOP); end
    tick();
    #1;
    total++; if (bus2.done !== 1'b0) begin bad++; $display("FAIL pop_done_pulse got=%0b want=0", bus2.done); end
    bus2.mem_ack = 1'b0;
  endtask

  task automatic test_cbf_4seg();
    logic [1:0] exp_seg [3];
    exp_seg[0] = 2'd1; exp_seg[1] = 2'd2; exp_seg[2] = 2'd3;
    tick();
    bus4.start = 1'b1; bus4.instruction = CBF; bus4.mem_ack = 1'b1;
    tick();
    bus4.start = 1'b0;
    for (int p = 0; p < 3; p++) begin
      #1;
      total++; if (bus4.busy !== 1'b1) begin bad++; $display("FAIL cbf_busy ph=%0d got=%0b want=1", p, bus4.busy); end
      total++; if (bus4.seg_sel !== exp_seg[p]) begin bad++; $display("FAIL cbf_seg ph=%0d got=%0d want=%0d", p, bus4.seg_sel, exp_seg[p]); end
      if (p == 2) begin
        total++; if (bus4.controls !== CBF_LAST) begin bad++; $display("FAIL cbf_ctl ph=%0d got=%h want=%h", p, bus4.controls, CBF_LAST); end
      end else begin
        total++; if (bus4.controls !== CBF_MID) begin bad++; $display("FAIL cbf_ctl ph=%0d got=%h want=%h", p, bus4.controls, CBF_MID); end
      end
      tick();
    end
    #1;
    total++; if (bus4.done !== 1'b1) begin bad++; $display("FAIL cbf_done got=%0b want=1", bus4.done); end
    total++; if (bus4.busy !== 1'b0) begin bad++; $display("FAIL cbf_end_busy got=%0b want=0", bus4.busy); end
    bus4.mem_ack = 1'b0;
  endtask

  task automatic test_cbb_wait();
    int nb;
    nb = 0;
    tick();
    bus4.start = 1'b1; bus4.instruction = CBB; bus4.mem_ack = 1'b1;
    tick();
    bus4.start = 1'b0;
    #1;
    nb += int'(bus4.busy);
    total++; if (bus4.seg_sel !== 2'd1) begin bad++; $display("FAIL cbb_seg0 got=%0d want=1", bus4.seg_sel); end
    total++; if (bus4.controls !== CBB_MID) begin bad++; $display("FAIL cbb_ctl0 got=%h want=%h", bus4.controls, CBB_MID); end
    tick();
    bus4.mem_ack = 1'b0;
    for (int w = 0; w < 2; w++) begin
      #1;
      nb += int'(bus4.busy);
      total++; if (bus4.seg_sel !== 2'd2) begin bad++; $display("FAIL cbb_hold_seg w=%0d got=%0d want=2", w, bus4.seg_sel); end
      total++; if (bus4.controls !== CBB_MID) begin bad++; $display("FAIL cbb_hold_ctl w=%0d got=%h want=%h", w, bus4.controls, CBB_MID); end
      tick();
    end
    bus4.mem_ack = 1'b1;
    #1;
    nb += int'(bus4.busy);
    total++; if (bus4.seg_sel !== 2'd2) begin bad++; $display("FAIL cbb_seg1 got=%0d want=2", bus4.seg_sel); end
    tick();
    #1;
    nb += int'(bus4.busy);
    total++; if (bus4.seg_sel !== 2'd3) begin bad++; $display("FAIL cbb_seg2 got=%0d want=3", bus4.seg_sel); end
    total++; if (bus4.controls !== CBB_LAST) begin bad++; $display("FAIL cbb_ctl_last got=%h want=%h", bus4.controls, CBB_LAST); end
    tick();
    #1;
    nb += int'(bus4.busy);
    total++; if (bus4.done !== 1'b1) begin bad++; $display("FAIL cbb_done got=%0b want=1", bus4.done); end
    total++; if (nb !== 5) begin bad++; $display("FAIL cbb_busy_cycles got=%0d want=5", nb); end
    bus4.mem_ack = 1'b0;
  endtask

  task automatic test_zero_len();
    tick();
    bus1.start = 1'b1; bus1.instruction = CBF; bus1.mem_ack = 1'b1;
    tick();
    bus1.start = 1'b0;
    #1;
    total++; if (bus1.done !== 1'b1) begin bad++; $display("FAIL zl_done got=%0b want=1", bus1.done); end
    total++; if (bus1.busy !== 1'b0) begin bad++; $display("FAIL zl_busy got=%0b want=0", bus1.busy); end
    total++; if (bus1.controls !== NOP) begin bad++; $display("FAIL zl_ctl got=%h want=%h", bus1.controls, NOP); end
    total++; if (bus1.seg_sel !== 1'b0) begin bad++; $display("FAIL zl_seg got=%0d want=0", bus1.seg_sel); end
    tick();
    #1;
    total++; if (bus1.done !== 1'b0) begin bad++; $display("FAIL zl_done_pulse got=%0b want=0", bus1.done); end
    bus1.mem_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    tick();
    bus3.start = 1'b1; bus3.instruction = CBB; bus3.mem_ack = 1'b1;
    tick();
    bus3.start = 1'b0;
    #1;
    total++; if (bus3.seg_sel !== 2'd1) begin bad++; $display("FAIL rm_seg0 got=%0d want=1", bus3.seg_sel); end
    tick();
    bus3.mem_ack = 1'b0;
    #1;
    total++; if (bus3.controls !== CBB_LAST_WAIT) begin bad++; $display("FAIL rm_ctl_wait got=%h want=%h", bus3.controls, CBB_LAST_WAIT); end
    bus3.mem_ack = 1'b1;
    reset = 1'b1;
    tick();
    #1;
    total++; if (bus3.busy !== 1'b0) begin bad++; $display("FAIL rm_busy got=%0b want=0", bus3.busy); end
    total++; if (bus3.done !== 1'b0) begin bad++; $display("FAIL rm_done got=%0b want=0", bus3.done); end
    total++; if (bus3.seg_sel !== 2'd0) begin bad++; $display("FAIL rm_seg got=%0d want=0", bus3.seg_sel); end
    total++; if (bus3.controls !== NOP) begin bad++; $display("FAIL rm_ctl got=%h want=%h", bus3.controls, NOP); end
    reset = 1'b0;
    bus3.mem_ack = 1'b0;
    tick();
    #1;
    total++; if (bus3.done !== 1'b0) begin bad++; $display("FAIL rm_late_done got=%0b want=0", bus3.done); end
  endtask

  task automatic test_restart_ignored();
    tick();
    bus3.start = 1'b1; bus3.instruction = CBF; bus3.mem_ack = 1'b1;
    tick();
    bus3.instruction = POP;
    #1;
    total++; if (bus3.seg_sel !== 2'd1) begin bad++; $display("FAIL rs_seg0 got=%0d want=1", bus3.seg_sel); end
    total++; if (bus3.controls !== CBF_MID) begin bad++; $display("FAIL rs_ctl0 got=%h want=%h", bus3.controls, CBF_MID); end
    tick();
    #1;
    total++; if (bus3.seg_sel !== 2'd2) begin bad++; $display("FAIL rs_seg1 got=%0d want=2", bus3.seg_sel); end
    total++; if (bus3.controls !== CBF_LAST) begin bad++; $display("FAIL rs_ctl1 got=%h want=%h", bus3.controls, CBF_LAST); end
    tick();
    bus3.start = 1'b0;
    #1;
    total++; if (bus3.done !== 1'b1) begin bad++; $display("FAIL rs_done got=%0b want=1", bus3.done); end
    total++; if (bus3.busy !== 1'b0) begin bad++; $display("FAIL rs_end_busy got=%0b want=0", bus3.busy); end
    tick();
    #1;
    total++; if (bus3.done !== 1'b0) begin bad++; $display("FAIL rs_done_pulse got=%0b want=0", bus3.done); end
    bus3.mem_ack = 1'b0;
  endtask

  initial begin
    NOP           = mk(DISABLE, ALU_INC, ALU_FROM_CACHE, DISABLE, ADDR_FROM_HEAD,
                       MEM_FROM_ACC, MEM_NONE, PC_INCREMENTED, DISABLE, CORE_S);
    POP_LAST      = mk(DISABLE, ALU_DEC, ALU_FROM_STACK, DISABLE, ADDR_FROM_HEAD,
                       MEM_FROM_ACC, MEM_WRITE, PC_INCREMENTED, ENABLE, CORE_S);
    CBF_MID       = mk(ENABLE, ALU_INC, ALU_FROM_CACHE, ENABLE, ADDR_FROM_ALU,
                       MEM_FROM_PC, MEM_WRITE, PC_INCREMENTED, DISABLE, STALL_S);
    CBF_LAST      = mk(ENABLE, ALU_INC, ALU_FROM_CACHE, ENABLE, ADDR_FROM_ALU,
                       MEM_FROM_PC, MEM_WRITE, PC_INCREMENTED, ENABLE, CORE_S);
    CBB_MID       = mk(ENABLE, ALU_DEC, ALU_FROM_CACHE, ENABLE, ADDR_FROM_ALU,
                       MEM_FROM_ACC, MEM_READ, PC_LOADED, DISABLE, STALL_S);
    CBB_LAST      = mk(DISABLE, ALU_DEC, ALU_FROM_CACHE, ENABLE, ADDR_FROM_ALU,
                       MEM_FROM_ACC, MEM_READ, PC_LOADED, ENABLE, CORE_S);
    CBB_LAST_WAIT = mk(DISABLE, ALU_DEC, ALU_FROM_CACHE, ENABLE, ADDR_FROM_ALU,
                       MEM_FROM_ACC, MEM_READ, PC_LOADED, DISABLE, STALL_S);

    bus1.start = 1'b0; bus1.instruction = POP; bus1.mem_ack = 1'b0;
    bus2.start = 1'b0; bus2.instruction = POP; bus2.mem_ack = 1'b0;
    bus3.start = 1'b0; bus3.instruction = POP; bus3.mem_ack = 1'b0;
    bus4.start = 1'b0; bus4.instruction = POP; bus4.mem_ack = 1'b0;

    test_reset();
    test_pop();
    test_cbf_4seg();
    test_cbb_wait();
    test_zero_len();
    test_reset_mid();
    test_restart_ignored();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
